// File: rtl/pll_pkg.sv
// Shared definitions for the injection-locked PLL datapath: timing constants,
// the phase-detector state encoding and the phase word type that the
// downstream low-pass / tunable-delay stage also consumes.
package pll_pkg;

    localparam int CLK_HZ    = 10_000_000;
    localparam int REF_HZ    = 20_000;
    localparam int REF_TICKS = CLK_HZ / REF_HZ;   // 500 ticks per reference period
    localparam int CNT_W     = 10;
    localparam int CENTER    = 250;
    localparam int MAX_CNT   = 511;
    localparam int PULSE_LEN = 8;

    typedef enum logic [1:0] {
        WAIT_REF = 2'd0,
        COUNT    = 2'd1,
        LOST     = 2'd2
    } pd_state_e;

    typedef logic signed [7:0] phase_t;

    // Clamp a sign-extended difference into the signed 8-bit phase range.
    function automatic phase_t saturate_phase(input logic signed [15:0] diff);
        if (diff > 16'sd127) begin
            return 8'sh7F;
        end else if (diff < -16'sd128) begin
            return 8'sh80;
        end else begin
            return phase_t'(diff[7:0]);
        end
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for an asynchronous input followed by a history flop,
// producing a single-cycle strobe on each rising edge. Reference and response
// paths use identical instances so their latencies match exactly.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic hist_q,  hist_d;

    // Shift the input one stage per clock through the synchroniser and history.
    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
    end

    // Synchroniser and history registers, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
        end
    end

    assign rise = sync2_q & ~hist_q;

endmodule

// File: rtl/phase_detector.sv
// Phase detector: counts clock ticks from a reference rising edge to the next
// response rising edge, removes the centre offset and saturates the result
// into a signed 8-bit phase word, once per reference period. Also produces a
// stretched sample strobe for the downstream filter and a loss-of-lock flag.
module phase_detector #(
    parameter int CNT_W     = 10,
    parameter int CENTER    = 250,
    parameter int MAX_CNT   = 511,
    parameter int PULSE_LEN = 8
) (
    input  logic       clk10MHz,
    input  logic       rst_n,
    input  logic       ref_in,
    input  logic       resp_in,
    output logic [7:0] phase,
    output logic       phase_valid,
    output logic       pulse20kHz,
    output logic       lost
);

    import pll_pkg::*;

    localparam int PULSE_W = $clog2(PULSE_LEN + 1);

    logic ref_rise;
    logic resp_rise;

    pd_state_e            state_q,       state_d;
    logic [CNT_W-1:0]     cnt_q,         cnt_d;
    phase_t               phase_q,       phase_d;
    logic                 phase_valid_q, phase_valid_d;
    logic                 lost_q,        lost_d;
    logic [PULSE_W-1:0]   pulse_cnt_q,   pulse_cnt_d;

    logic [CNT_W-1:0]     meas;
    logic signed [CNT_W:0] diff;
    logic signed [15:0]   diff_wide;

    edge_sync u_ref_sync (
        .clk      (clk10MHz),
        .rst_n    (rst_n),
        .async_in (ref_in),
        .rise     (ref_rise)
    );

    edge_sync u_resp_sync (
        .clk      (clk10MHz),
        .rst_n    (rst_n),
        .async_in (resp_in),
        .rise     (resp_rise)
    );

    // cnt_q is zero in the first tick after the reference edge, so the tick
    // distance between the two edges is cnt_q + 1 in the response-edge cycle.
    always_comb begin
        meas      = cnt_q + CNT_W'(1);
        diff      = $signed({1'b0, meas}) - $signed((CNT_W + 1)'(CENTER));
        diff_wide = 16'(diff);
    end

    // Measurement FSM: wait for a reference edge, count to the response edge,
    // flag loss on a missed period or when the counter hits its ceiling.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        phase_d       = phase_q;
        phase_valid_d = 1'b0;
        lost_d        = lost_q;
        case (state_q)
            WAIT_REF: begin
                if (ref_rise) begin
                    state_d = COUNT;
                    cnt_d   = '0;
                end
            end
            COUNT: begin
                if (resp_rise) begin
                    phase_d       = saturate_phase(diff_wide);
                    phase_valid_d = 1'b1;
                    lost_d        = 1'b0;
                    cnt_d         = '0;
                    state_d       = ref_rise ? COUNT : WAIT_REF;
                end else if (ref_rise) begin
                    lost_d  = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(MAX_CNT)) begin
                    state_d = LOST;
                    lost_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            LOST: begin
                if (ref_rise) begin
                    state_d = COUNT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = WAIT_REF;
                cnt_d   = '0;
            end
        endcase
    end

    // Sample strobe stretcher: reload on every new phase word, else count down.
    always_comb begin
        pulse_cnt_d = pulse_cnt_q;
        if (phase_valid_d) begin
            pulse_cnt_d = PULSE_W'(PULSE_LEN);
        end else if (pulse_cnt_q != '0) begin
            pulse_cnt_d = pulse_cnt_q - PULSE_W'(1);
        end
    end

    // State, counter and output registers; reset aborts any measurement.
    always_ff @(posedge clk10MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= WAIT_REF;
            cnt_q         <= '0;
            phase_q       <= '0;
            phase_valid_q <= 1'b0;
            lost_q        <= 1'b0;
            pulse_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            phase_q       <= phase_d;
            phase_valid_q <= phase_valid_d;
            lost_q        <= lost_d;
            pulse_cnt_q   <= pulse_cnt_d;
        end
    end

    assign phase       = phase_q;
    assign phase_valid = phase_valid_q;
    assign lost        = lost_q;
    assign pulse20kHz  = (pulse_cnt_q != '0);

endmodule

// File: tb/tb_phase_detector.sv
// Self-checking bench for phase_detector: a table of reference-to-response
// delays with their expected phase words, a scoreboard queue checked whenever
// phase_valid fires, and hand-written sequences for the multi-cycle cases.
module tb_phase_detector;

    logic       clk10MHz = 1'b0;
    logic       rst_n    = 1'b0;
    logic       ref_in   = 1'b0;
    logic       resp_in  = 1'b0;
    logic [7:0] phase;
    logic       phase_valid;
    logic       pulse20kHz;
    logic       lost;

    int         checks      = 0;
    int         errors      = 0;
    int         valid_count = 0;
    logic [7:0] last_phase  = 8'h00;
    logic [7:0] exp_q[$];

    typedef struct {
        int         delay;
        logic [7:0] exp_phase;
    } vec_t;

    vec_t vecs[11];

    phase_detector dut (
        .clk10MHz    (clk10MHz),
        .rst_n       (rst_n),
        .ref_in      (ref_in),
        .resp_in     (resp_in),
        .phase       (phase),
        .phase_valid (phase_valid),
        .pulse20kHz  (pulse20kHz),
        .lost        (lost)
    );

    // 10 MHz clock, 10 time units per period.
    always #5 clk10MHz = ~clk10MHz;

    // Compare one observed value against its required value.
    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every phase_valid must match the oldest pending expectation.
    always @(negedge clk10MHz) begin
        if (rst_n && phase_valid) begin
            valid_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid: got phase 0x%0h, expected no strobe", phase);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check_output("phase", 32'(phase), 32'(e));
                check_output("lost_on_valid", 32'(lost), 32'd0);
                check_output("pulse_with_valid", 32'(pulse20kHz), 32'd1);
                last_phase = e;
            end
        end
    end

    // Wait for phase_valid within a small budget, then measure the strobe width.
    task automatic wait_valid_and_pulse(input string name);
        int n;
        n = 0;
        while (!phase_valid && n < 10) begin
            @(negedge clk10MHz);
            n++;
        end
        if (!phase_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got no phase_valid, expected one within 10 cycles", name);
        end else begin
            n = 0;
            while (pulse20kHz && n < 20) begin
                @(negedge clk10MHz);
                n++;
            end
            check_output({name, "_pulse_len"}, 32'(n), 32'd8);
        end
    endtask

    // One full ref -> resp period with the response edge `delay` ticks late.
    task automatic apply_stimulus(input int delay, input logic [7:0] exp_phase, input string name);
        @(negedge clk10MHz);
        ref_in = 1'b1;
        for (int i = 1; i <= delay; i++) begin
            @(negedge clk10MHz);
            if (i == 10) ref_in = 1'b0;
        end
        exp_q.push_back(exp_phase);
        resp_in = 1'b1;
        wait_valid_and_pulse(name);
        resp_in = 1'b0;
        ref_in  = 1'b0;
        repeat (5) @(negedge clk10MHz);
    endtask

    // Whole-run watchdog so the bench can never hang.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int vc;
        vecs[0]  = '{250, 8'h00};
        vecs[1]  = '{260, 8'h0A};
        vecs[2]  = '{400, 8'h7F};
        vecs[3]  = '{100, 8'h80};
        vecs[4]  = '{200, 8'hCE};
        vecs[5]  = '{376, 8'h7E};
        vecs[6]  = '{377, 8'h7F};
        vecs[7]  = '{378, 8'h7F};
        vecs[8]  = '{123, 8'h81};
        vecs[9]  = '{121, 8'h80};
        vecs[10] = '{249, 8'hFF};

        // Reset state
        repeat (3) @(negedge clk10MHz);
        check_output("reset_phase", 32'(phase), 32'd0);
        check_output("reset_valid", 32'(phase_valid), 32'd0);
        check_output("reset_pulse", 32'(pulse20kHz), 32'd0);
        check_output("reset_lost", 32'(lost), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk10MHz);

        // Table-driven delays
        for (int k = 0; k < 11; k++) begin
            apply_stimulus(vecs[k].delay, vecs[k].exp_phase, $sformatf("vec%0d", k));
        end

        // Missing response: counter hits its ceiling, phase holds
        @(negedge clk10MHz);
        ref_in = 1'b1;
        for (int i = 1; i <= 520; i++) begin
            @(negedge clk10MHz);
            if (i == 10) ref_in = 1'b0;
            if (i == 505) check_output("lost_before_max", 32'(lost), 32'd0);
        end
        check_output("lost_after_max", 32'(lost), 32'd1);
        check_output("phase_hold_lost", 32'(phase), 32'(last_phase));
        apply_stimulus(250, 8'h00, "recover");
        check_output("lost_cleared", 32'(lost), 32'd0);

        // Double reference: second ref edge with no response in between
        @(negedge clk10MHz);
        ref_in = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk10MHz);
            if (i == 10) ref_in = 1'b0;
        end
        ref_in = 1'b1;
        repeat (5) @(negedge clk10MHz);
        check_output("lost_double_ref", 32'(lost), 32'd1);
        for (int i = 6; i <= 250; i++) begin
            @(negedge clk10MHz);
            if (i == 10) ref_in = 1'b0;
        end
        exp_q.push_back(8'h00);
        resp_in = 1'b1;
        wait_valid_and_pulse("double_ref");
        check_output("lost_after_double", 32'(lost), 32'd0);
        resp_in = 1'b0;
        repeat (5) @(negedge clk10MHz);

        // Simultaneous ref and resp in WAIT_REF: resp edge must be ignored
        @(negedge clk10MHz);
        ref_in  = 1'b1;
        resp_in = 1'b1;
        for (int i = 1; i <= 250; i++) begin
            @(negedge clk10MHz);
            if (i == 10) begin
                ref_in  = 1'b0;
                resp_in = 1'b0;
            end
        end
        exp_q.push_back(8'h00);
        resp_in = 1'b1;
        wait_valid_and_pulse("simul_wait");
        resp_in = 1'b0;
        repeat (5) @(negedge clk10MHz);

        // Simultaneous ref and resp in COUNT: measure and restart in one cycle
        @(negedge clk10MHz);
        ref_in = 1'b1;
        for (int i = 1; i <= 250; i++) begin
            @(negedge clk10MHz);
            if (i == 10) ref_in = 1'b0;
        end
        exp_q.push_back(8'h00);
        ref_in  = 1'b1;
        resp_in = 1'b1;
        for (int i = 1; i <= 260; i++) begin
            @(negedge clk10MHz);
            if (i == 10) begin
                ref_in  = 1'b0;
                resp_in = 1'b0;
            end
        end
        exp_q.push_back(8'h0A);
        resp_in = 1'b1;
        wait_valid_and_pulse("simul_count");
        resp_in = 1'b0;
        repeat (5) @(negedge clk10MHz);

        // Reset mid-COUNT with lost set and a non-zero phase held
        @(negedge clk10MHz);
        ref_in = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk10MHz);
            if (i == 10) ref_in = 1'b0;
        end
        ref_in = 1'b1;
        for (int i = 1; i <= 121; i++) begin
            @(negedge clk10MHz);
            if (i == 10) ref_in = 1'b0;
        end
        check_output("lost_pre_reset", 32'(lost), 32'd1);
        check_output("phase_pre_reset", 32'(phase), 32'h0A);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_reset_phase", 32'(phase), 32'd0);
        check_output("async_reset_valid", 32'(phase_valid), 32'd0);
        check_output("async_reset_pulse", 32'(pulse20kHz), 32'd0);
        check_output("async_reset_lost", 32'(lost), 32'd0);
        last_phase = 8'h00;
        repeat (3) @(negedge clk10MHz);
        rst_n = 1'b1;
        vc = valid_count;
        repeat (5) @(negedge clk10MHz);
        resp_in = 1'b1;
        repeat (300) @(negedge clk10MHz);
        check_output("no_valid_after_reset", 32'(valid_count), 32'(vc));
        check_output("phase_after_reset", 32'(phase), 32'd0);
        resp_in = 1'b0;
        repeat (5) @(negedge clk10MHz);
        apply_stimulus(250, 8'h00, "post_reset");
        apply_stimulus(200, 8'hCE, "post_reset2");

        check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
